// File: rtl/ex_rf_fwd_unit.sv
// RF-stage operand forwarding and load-use stall detection: tracks the destination of the
// instructions in EX/MEM/WB and selects the newest producer for each RF source operand.

module ex_rf_fwd_op #(
    parameter int REG_W    = 5,
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31
) (
    input  logic [REG_W-1:0]            src_i,
    input  logic                        used_i,
    input  logic [2:0][REG_W-1:0]       rd_i,    // 0=EX, 1=MEM, 2=WB
    input  logic [2:0]                  wr_i,
    input  logic [3:0][DATA_W-1:0]      cand_i,  // indexed by select code
    output logic [1:0]                  sel_o,
    output logic [DATA_W-1:0]           data_o,
    output logic                        ex_hit_o
);
    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    logic [2:0] hit;

    always_comb begin
        for (int s = 0; s < 3; s++)
            hit[s] = wr_i[s] && (rd_i[s] == src_i) && used_i && (src_i != ZR);
    end

    // Newest producer wins: EX over MEM over WB.
    always_comb begin
        sel_o = 2'd0;
        if (hit[0])      sel_o = 2'd1;
        else if (hit[1]) sel_o = 2'd2;
        else if (hit[2]) sel_o = 2'd3;
    end

    assign data_o   = cand_i[sel_o];
    assign ex_hit_o = hit[0];
endmodule

module ex_rf_fwd_unit #(
    parameter int REG_W    = 5,
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_W-1:0]  rf_rn_i,
    input  logic [REG_W-1:0]  rf_rm_i,
    input  logic              rf_rn_used_i,
    input  logic              rf_rm_used_i,
    input  logic [REG_W-1:0]  rf_rd_i,
    input  logic              rf_regwrite_i,
    input  logic              rf_load_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] ex_result_i,
    input  logic [DATA_W-1:0] mem_result_i,
    input  logic [DATA_W-1:0] wb_result_i,
    input  logic [DATA_W-1:0] rf_data_a_i,
    input  logic [DATA_W-1:0] rf_data_b_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic [DATA_W-1:0] fwd_a_data_o,
    output logic [DATA_W-1:0] fwd_b_data_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_count_o
);
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             wr;
    } trk_t;

    // The load flag only matters while the producer sits in EX, so it is not carried further.
    trk_t             ex_q, mem_q, wb_q, ex_d;
    logic             ex_ld_q, ex_ld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0][REG_W-1:0]     src;
    logic [1:0]                used;
    logic [1:0][1:0]           sel;
    logic [1:0][DATA_W-1:0]    data;
    logic [1:0]                ex_hit;
    logic [1:0][DATA_W-1:0]    rf_data;

    assign src     = {rf_rm_i, rf_rn_i};
    assign used    = {rf_rm_used_i, rf_rn_used_i};
    assign rf_data = {rf_data_b_i, rf_data_a_i};

    for (genvar g = 0; g < 2; g++) begin : g_op
        ex_rf_fwd_op #(.REG_W(REG_W), .DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_op (
            .src_i    (src[g]),
            .used_i   (used[g]),
            .rd_i     ({wb_q.rd, mem_q.rd, ex_q.rd}),
            .wr_i     ({wb_q.wr, mem_q.wr, ex_q.wr}),
            .cand_i   ({wb_result_i, mem_result_i, ex_result_i, rf_data[g]}),
            .sel_o    (sel[g]),
            .data_o   (data[g]),
            .ex_hit_o (ex_hit[g])
        );
    end

    assign fwd_a_sel_o  = sel[0];
    assign fwd_b_sel_o  = sel[1];
    assign fwd_a_data_o = data[0];
    assign fwd_b_data_o = data[1];

    // A squashed instruction never stalls.
    assign stall_o       = ~flush_i & ex_ld_q & ex_q.wr & (|ex_hit);
    assign stall_count_o = cnt_q;

    always_comb begin
        ex_d    = '{rd: rf_rd_i, wr: rf_regwrite_i};
        ex_ld_d = rf_load_i;
        if (stall_o || flush_i) begin
            ex_d    = '0;
            ex_ld_d = 1'b0;
        end
        cnt_d = cnt_q;
        if (stall_o && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            ex_ld_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            ex_q    <= ex_d;
            ex_ld_q <= ex_ld_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ex_rf_fwd_unit.sv
// Bench for ex_rf_fwd_unit: directed vector table, random stream against a history model,
// counter saturation on a narrow-counter instance, and asynchronous mid-stream reset.

module tb_ex_rf_fwd_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [4:0]  rn, rm, rd;
    logic        rn_u, rm_u, wr, ld, fl;
    logic [63:0] d_ex, d_mem, d_wb, d_ra, d_rb;

    logic [1:0]  sel_a, sel_b, s_sel_a, s_sel_b;
    logic [63:0] dat_a, dat_b, s_dat_a, s_dat_b;
    logic        stall, s_stall;
    logic [15:0] cnt;
    logic [3:0]  s_cnt;

    ex_rf_fwd_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .rf_rn_i(rn), .rf_rm_i(rm),
        .rf_rn_used_i(rn_u), .rf_rm_used_i(rm_u), .rf_rd_i(rd), .rf_regwrite_i(wr),
        .rf_load_i(ld), .flush_i(fl), .ex_result_i(d_ex), .mem_result_i(d_mem),
        .wb_result_i(d_wb), .rf_data_a_i(d_ra), .rf_data_b_i(d_rb),
        .fwd_a_sel_o(sel_a), .fwd_b_sel_o(sel_b), .fwd_a_data_o(dat_a), .fwd_b_data_o(dat_b),
        .stall_o(stall), .stall_count_o(cnt)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    ex_rf_fwd_unit #(.CNT_W(4)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .rf_rn_i(rn), .rf_rm_i(rm),
        .rf_rn_used_i(rn_u), .rf_rm_used_i(rm_u), .rf_rd_i(rd), .rf_regwrite_i(wr),
        .rf_load_i(ld), .flush_i(fl), .ex_result_i(d_ex), .mem_result_i(d_mem),
        .wb_result_i(d_wb), .rf_data_a_i(d_ra), .rf_data_b_i(d_rb),
        .fwd_a_sel_o(s_sel_a), .fwd_b_sel_o(s_sel_b), .fwd_a_data_o(s_dat_a), .fwd_b_data_o(s_dat_b),
        .stall_o(s_stall), .stall_count_o(s_cnt)
    );

    typedef struct {
        logic [4:0] rn, rm;
        logic       rn_u, rm_u;
        logic [4:0] rd;
        logic       wr, ld, fl;
        logic [1:0] ea, eb;
        logic       es;
    } vec_t;

    typedef struct {
        logic [4:0] rd;
        logic       wr, ld;
    } ent_t;

    ent_t hist[3];      // hist[0] = most recently issued (in EX)
    int   m_stalls;
    int   n_chk, n_err;
    vec_t tbl[18];

    function automatic vec_t mk(int a, int b, int au, int bu, int d, int w, int l, int f,
                                int ea, int eb, int es);
        vec_t v;
        v.rn = 5'(a); v.rm = 5'(b); v.rn_u = 1'(au); v.rm_u = 1'(bu);
        v.rd = 5'(d); v.wr = 1'(w); v.ld = 1'(l); v.fl = 1'(f);
        v.ea = 2'(ea); v.eb = 2'(eb); v.es = 1'(es);
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_sel(logic [4:0] src, logic used);
        if (!used || src == 5'd31) return 2'd0;
        for (int s = 0; s < 3; s++)
            if (hist[s].wr && hist[s].rd == src) return 2'(s + 1);
        return 2'd0;
    endfunction

    function automatic logic m_stall(vec_t v);
        return !v.fl && hist[0].wr && hist[0].ld &&
               (m_sel(v.rn, v.rn_u) == 2'd1 || m_sel(v.rm, v.rm_u) == 2'd1);
    endfunction

    function automatic logic [63:0] pick(logic [1:0] s, logic [63:0] rf);
        case (s)
            2'd1:    return d_ex;
            2'd2:    return d_mem;
            2'd3:    return d_wb;
            default: return rf;
        endcase
    endfunction

    function automatic int sat(int n, int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic clear_model();
        for (int s = 0; s < 3; s++) hist[s] = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};
        m_stalls = 0;
    endtask

    task automatic drive(vec_t v);
        rn = v.rn; rm = v.rm; rn_u = v.rn_u; rm_u = v.rm_u;
        rd = v.rd; wr = v.wr; ld = v.ld; fl = v.fl;
        d_ex  = {$urandom, $urandom}; d_mem = {$urandom, $urandom};
        d_wb  = {$urandom, $urandom}; d_ra  = {$urandom, $urandom};
        d_rb  = {$urandom, $urandom};
    endtask

    task automatic check_outs(string tag, logic [1:0] ea, logic [1:0] eb, logic es);
        chk({tag, "_sel_a"},  64'(sel_a), 64'(ea));
        chk({tag, "_sel_b"},  64'(sel_b), 64'(eb));
        chk({tag, "_stall"},  64'(stall), 64'(es));
        chk({tag, "_data_a"}, dat_a, pick(ea, d_ra));
        chk({tag, "_data_b"}, dat_b, pick(eb, d_rb));
        chk({tag, "_s_sel_a"}, 64'(s_sel_a), 64'(ea));
        chk({tag, "_s_stall"}, 64'(s_stall), 64'(es));
    endtask

    // Clock edge, then model advance and counter comparison.
    task automatic advance(vec_t v);
        logic st;
        st = m_stall(v);
        @(posedge clk);
        if (st) m_stalls++;
        hist[2] = hist[1];
        hist[1] = hist[0];
        if (st || v.fl) hist[0] = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};
        else            hist[0] = '{rd: v.rd, wr: v.wr, ld: v.ld};
        #1;
        chk("stall_count",   64'(cnt),   64'(sat(m_stalls, 65535)));
        chk("stall_count_s", 64'(s_cnt), 64'(sat(m_stalls, 15)));
    endtask

    task automatic model_cycle(string tag, vec_t v);
        drive(v);
        #4;
        check_outs(tag, m_sel(v.rn, v.rn_u), m_sel(v.rm, v.rm_u), m_stall(v));
        advance(v);
    endtask

    function automatic logic [4:0] rnd_reg();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        vec_t v;
        n_chk = 0; n_err = 0;
        clear_model();
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        check_outs("reset", 2'd0, 2'd0, 1'b0);
        chk("reset_count", 64'(cnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // rn, rm, rn_u, rm_u, rd, wr, ld, flush, exp_sel_a, exp_sel_b, exp_stall
        tbl[0]  = mk( 0,  0, 0, 0,  1, 1, 0, 0, 0, 0, 0);  // ADD X1
        tbl[1]  = mk( 1,  0, 1, 0,  7, 1, 0, 0, 1, 0, 0);  // use X1 from EX
        tbl[2]  = mk( 9,  0, 1, 0,  2, 1, 1, 0, 0, 0, 0);  // LDUR X2
        tbl[3]  = mk( 2,  4, 1, 1,  3, 1, 0, 0, 1, 0, 1);  // load-use: stall
        tbl[4]  = mk( 2,  4, 1, 1,  3, 1, 0, 0, 2, 0, 0);  // held, load now in MEM
        tbl[5]  = mk( 0,  0, 0, 0,  5, 1, 0, 0, 0, 0, 0);  // ADD X5
        tbl[6]  = mk( 0,  0, 0, 0,  5, 1, 0, 0, 0, 0, 0);  // ADD X5
        tbl[7]  = mk( 0,  5, 0, 1,  8, 1, 0, 0, 0, 1, 0);  // newest X5 wins
        tbl[8]  = mk( 0,  0, 0, 0, 12, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk( 0,  0, 0, 0, 13, 1, 0, 0, 0, 0, 0);
        tbl[10] = mk( 0, 12, 0, 1, 14, 1, 0, 0, 0, 2, 0);  // X12 from MEM
        tbl[11] = mk( 0,  0, 0, 0, 16, 1, 0, 0, 0, 0, 0);
        tbl[12] = mk( 0,  0, 0, 0, 17, 1, 0, 0, 0, 0, 0);
        tbl[13] = mk( 0,  0, 0, 0, 18, 1, 0, 0, 0, 0, 0);
        tbl[14] = mk(17, 16, 1, 1, 31, 1, 0, 0, 2, 3, 0);  // MEM on A, WB on B
        tbl[15] = mk(31, 31, 1, 1,  6, 1, 1, 0, 0, 0, 0);  // XZR never forwards
        tbl[16] = mk( 6,  0, 1, 0, 20, 1, 0, 1, 1, 0, 0);  // flush beats load-use
        tbl[17] = mk(20,  6, 1, 0,  0, 0, 0, 0, 0, 0, 0);  // squashed rd not tracked

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i]);
            #4;
            check_outs($sformatf("tbl%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].es);
            advance(tbl[i]);
        end
        chk("tbl_stall_count", 64'(cnt), 64'd1);

        // Repeated load-use on the same register: stalls every other cycle, saturating the narrow counter.
        v = mk(2, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) model_cycle("sat", v);
        chk("sat_s_count", 64'(s_cnt), 64'hF);

        for (int i = 0; i < 400; i++) begin
            v.rn = rnd_reg(); v.rm = rnd_reg(); v.rd = rnd_reg();
            v.rn_u = 1'($urandom_range(0, 1)); v.rm_u = 1'($urandom_range(0, 1));
            v.wr = ($urandom_range(0, 3) != 0);
            v.ld = v.wr && ($urandom_range(0, 2) == 0);
            v.fl = ($urandom_range(0, 7) == 0);
            model_cycle("rnd", v);
        end

        // Mid-stream asynchronous reset with a live EX producer.
        v = mk(0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        model_cycle("pre_rst", v);
        v = mk(3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0);
        drive(v);
        #4;
        chk("pre_rst_sel_a", 64'(sel_a), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel_a", 64'(sel_a), 64'd0);
        chk("async_rst_sel_b", 64'(sel_b), 64'd0);
        chk("async_rst_stall", 64'(stall), 64'd0);
        chk("async_rst_count", 64'(cnt), 64'd0);
        chk("async_rst_s_count", 64'(s_cnt), 64'd0);
        chk("async_rst_data_a", dat_a, d_ra);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_model();
        drive(v);
        #4;
        chk("post_rst_sel_a", 64'(sel_a), 64'd0);
        chk("post_rst_sel_b", 64'(sel_b), 64'd0);
        advance(v);
        for (int i = 0; i < 4; i++) model_cycle("post_rst", v);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ex_rf_fwd_unit.md
Name: ex_rf_fwd_unit

Overview:
- Backward path of the RF→EX boundary. It tracks the destination register of every instruction in flight in the EX, MEM and WB stages.
- From that tracking it produces per-operand forwarding selects and forwarded 64-bit data for the RF stage.
- It raises a load-use stall, which freezes the RF stage and inserts a bubble into EX.
- It keeps a saturating stall counter for performance monitoring.

Parameters:
- REG_W, 5, register index width
- DATA_W, 64, datapath width
- ZERO_REG, 31, index of XZR; never forwarded, never hazards
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears all tracking state
- rf_rn  in  REG_W  source A index of instruction in RF
- rf_rm  in  REG_W  source B index of instruction in RF (Rd for STUR/CBZ, already muxed by Reg3Loc)
- rf_rn_used  in  1  source A actually read
- rf_rm_used  in  1  source B actually read
- rf_rd  in  REG_W  destination of instruction in RF
- rf_regwrite  in  1  RF instruction writes rf_rd
- rf_load  in  1  RF instruction is LDUR (read_en)
- flush  in  1  branch taken; RF instruction is squashed
- ex_result  in  DATA_W  ALU/normal result leaving EX this cycle
- mem_result  in  DATA_W  final writeback value leaving MEM (load data or ALU)
- wb_result  in  DATA_W  value being written to the register file
- rf_data_a  in  DATA_W  register-file read port A
- rf_data_b  in  DATA_W  register-file read port B
- fwd_a_sel  out  2  0=RF, 1=EX, 2=MEM, 3=WB
- fwd_b_sel  out  2  same encoding
- fwd_a_data  out  DATA_W  operand A after forwarding
- fwd_b_data  out  DATA_W  operand B after forwarding
- stall  out  1  load-use hazard; hold PC and IF/RF register
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Tracking state: three entries {rd, wr, ld} named EX, MEM and WB. All are updated on the rising clk edge.
- Each edge:
  - WB←MEM
  - MEM←EX
  - EX←{rf_rd, rf_regwrite, rf_load}, unless stall or flush is active; in that case EX←{0,0,0} (bubble).
- Reset low (asynchronous): every entry wr=0, ld=0, rd=0; stall_count=0. Outputs follow combinationally: sel=0, stall=0.
- Match rule for stage S and source x: S.wr=1, S.rd==x, x!=ZERO_REG, and the operand's used bit=1.
- Select priority, per operand: EX match → 1; else MEM match → 2; else WB match → 3; else 0.
  - The newest producer wins.
  - If EX and MEM both write the same register, the select is 1.
- An EX match with EX.ld=1 still reports sel=1, but stall=1 as well, and ex_result must not be consumed.
- fwd_x_data: combinational mux of rf_data_x / ex_result / mem_result / wb_result by fwd_x_sel. There is zero latency from the tracking state.
- stall = (EX.ld & EX.wr) & (match on A or match on B against EX), and flush=0.
  - flush has priority: a squashed instruction never stalls.
- Load-use latency: exactly 1 stall cycle.
  - After the bubble, the load sits in MEM; the next cycle selects 2 (mem_result = load data).
- Back-to-back stalls cannot occur for a single hazard. A new load issued after a stall may stall again normally.
- stall_count increments by 1 on each edge where stall=1. It holds at all-ones (saturates) and does not wrap.
- Write to XZR (rd=31): it is tracked in the entries but never matches, so sel=0.
- Reset asserted mid-operation: in-flight entries are discarded. The first post-reset cycle forwards nothing.

Test Plan:
- ADD X1 then SUB using X1 as rn: rf_rn=1 one cycle after rf_rd=1, rf_regwrite=1 → fwd_a_sel=1, fwd_a_data=ex_result (e.g. 0x0000_0000_0000_0005), stall=0.
- LDUR X2 then ADD X3,X2,X4 → stall=1 for exactly one cycle, EX bubble. Next cycle fwd_a_sel=2, fwd_a_data=mem_result=0xDEAD_BEEF_0000_0001. stall_count=1.
- ADD X5, ADD X5, then use X5 on rm → fwd_b_sel=1 (newest), not 2. Same stream with an unrelated instruction between → sel=2. Two unrelated instructions between → sel=3.
- Producer writes X31, consumer reads rn=31 → fwd_a_sel=0, fwd_a_data=rf_data_a, stall=0.
- LDUR X6 followed by use of X6 with flush=1 in the same cycle → stall=0, EX entry bubble, no forward next cycle.
- Force 65536 consecutive load-use stalls (CNT_W=16) → stall_count sticks at 0xFFFF. Assert reset low mid-stream → stall_count=0, all sel=0 immediately, without waiting for a clock edge.
